// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register slave: FSM states,
// register byte offsets and the fixed ID value.
package apb_slave_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [5:0] OFF_ID        = 6'h00;
    localparam logic [5:0] OFF_CTRL      = 6'h04;
    localparam logic [5:0] OFF_STATUS    = 6'h08;
    localparam logic [5:0] OFF_TRANS_CNT = 6'h0C;
    localparam logic [5:0] OFF_SCRATCH0  = 6'h10;

    localparam logic [3:0] IDX_ID        = OFF_ID[5:2];
    localparam logic [3:0] IDX_CTRL      = OFF_CTRL[5:2];
    localparam logic [3:0] IDX_STATUS    = OFF_STATUS[5:2];
    localparam logic [3:0] IDX_TRANS_CNT = OFF_TRANS_CNT[5:2];
    localparam logic [3:0] IDX_SCRATCH0  = OFF_SCRATCH0[5:2];

    localparam int          NUM_SCRATCH = 12;
    localparam int          STATUS_W    = 8;
    localparam logic [31:0] ID_VALUE    = 32'hA5B0_0001;

endpackage

// File: rtl/apb_slave_regbank.sv
// Register storage for the APB slave: RO ID/TRANS_CNT, RW CTRL/SCRATCH,
// W1C STATUS with event set, and the registered interrupt output.
module apb_slave_regbank
    import apb_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [3:0]            i_idx,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_done,
    input  logic [STATUS_W-1:0]   i_irq_src,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_irq
);

    logic [DATA_WIDTH-1:0] r_ctrl;
    logic [DATA_WIDTH-1:0] r_trans_cnt;
    logic [STATUS_W-1:0]   r_status;
    logic [DATA_WIDTH-1:0] r_scratch [NUM_SCRATCH];
    logic                  r_irq;

    logic                  w_wr_ctrl;
    logic                  w_wr_status;
    logic [STATUS_W-1:0]   w_clr;

    assign w_wr_ctrl   = i_wr_en && (i_idx == IDX_CTRL);
    assign w_wr_status = i_wr_en && (i_idx == IDX_STATUS);
    assign w_clr       = w_wr_status ? i_wdata[STATUS_W-1:0] : '0;
    assign o_irq       = r_irq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl      <= '0;
            r_trans_cnt <= '0;
            r_status    <= '0;
            r_irq       <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= '0;
        end else begin
            if (w_wr_ctrl) r_ctrl <= i_wdata;
            // OR-ing new events after the clear lets a coincident set win
            r_status <= (r_status & ~w_clr) | i_irq_src;
            if (i_done) r_trans_cnt <= r_trans_cnt + DATA_WIDTH'(1);
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (i_wr_en && (int'(i_idx) == int'(IDX_SCRATCH0) + i)) r_scratch[i] <= i_wdata;
            end
            r_irq <= |(r_status & r_ctrl[STATUS_W-1:0]);
        end
    end

    always_comb begin
        o_rdata = '0;
        case (i_idx)
            IDX_ID:        o_rdata = DATA_WIDTH'(ID_VALUE);
            IDX_CTRL:      o_rdata = r_ctrl;
            IDX_STATUS:    o_rdata = DATA_WIDTH'(r_status);
            IDX_TRANS_CNT: o_rdata = r_trans_cnt;
            default:       o_rdata = r_scratch[4'(i_idx - IDX_SCRATCH0)];
        endcase
    end

endmodule

// File: rtl/apb_reg_slave.sv
// APB slave with programmable wait states: setup/access FSM, wait counter
// and address decode in front of the register bank.
module apb_reg_slave
    import apb_slave_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    input  logic [STATUS_W-1:0]   irq_src_i,
    output logic                  irq_o
);

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic                  r_write;
    logic                  r_err;
    logic [3:0]            r_idx;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic                  w_setup;
    logic [3:0]            w_idx;
    logic                  w_err;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_setup = psel_i & ~penable_i;
    assign w_idx   = paddr_i[5:2];
    // Decoded at setup so the error flag is stable through the wait states
    assign w_err   = (paddr_i[1:0] != 2'b00)
                   | (paddr_i[ADDR_WIDTH-1:6] != '0)
                   | (pwrite_i & ((w_idx == IDX_ID) | (w_idx == IDX_TRANS_CNT)));

    assign pready_o  = (r_state == ACCESS) & (r_cnt == 4'd0) & psel_i & penable_i;
    assign pslverr_o = pready_o & r_err;
    assign prdata_o  = (pready_o & ~r_write & ~r_err) ? w_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= 4'd0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if ((r_state == IDLE) && w_setup) begin
                r_write <= pwrite_i;
                r_err   <= w_err;
                r_idx   <= w_idx;
                r_wdata <= pwdata_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = 4'(WAIT_CYCLES);
                end
            end
            ACCESS: begin
                if (!psel_i || pready_o) w_state_nxt = IDLE;
                else if (r_cnt != 4'd0)  w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    apb_slave_regbank #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_regbank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (pready_o & r_write & ~r_err),
        .i_idx     (r_idx),
        .i_wdata   (r_wdata),
        .i_done    (pready_o),
        .i_irq_src (irq_src_i),
        .o_rdata   (w_rdata),
        .o_irq     (irq_o)
    );

endmodule

// File: doc/apb_reg_slave.md
APB_REG_SLAVE -- requirements
Module: apb_reg_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted per access (0..15).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port psel_i  input  1  slave select, one psel bit from the bridge.
REQ-007 SHALL have port penable_i  input  1  APB access phase.
REQ-008 SHALL have port pwrite_i  input  1  1 = write, 0 = read.
REQ-009 SHALL have port paddr_i  input  ADDR_WIDTH  byte address.
REQ-010 SHALL have port pwdata_i  input  DATA_WIDTH  write data.
REQ-011 SHALL have port prdata_o  output  DATA_WIDTH  read data.
REQ-012 SHALL have port pready_o  output  1  transfer complete.
REQ-013 SHALL have port pslverr_o  output  1  transfer error.
REQ-014 SHALL have port irq_src_i  input  8  event pulses, one per STATUS bit.
REQ-015 SHALL have port irq_o  output  1  interrupt, level.

Function
REQ-016 SHALL use FSM states IDLE and ACCESS.
REQ-017 IDLE -> ACCESS on psel_i & ~penable_i (setup): latch paddr_i, pwrite_i, pwdata_i and the decode result; load wait counter with WAIT_CYCLES.
REQ-018 In ACCESS the counter SHALL decrement by 1 per cycle while nonzero; pready_o = (state==ACCESS) & (cnt==0) & psel_i & penable_i, combinational from registered state.
REQ-019 WAIT_CYCLES=0 SHALL give pready_o high in the first enable cycle, so the transfer takes 2 cycles in total; WAIT_CYCLES=N SHALL take N+2 cycles.
REQ-020 On the completing edge (pready_o high) the FSM SHALL commit the write, increment TRANS_CNT and return to IDLE.
REQ-021 psel_i low while in ACCESS SHALL abort: return to IDLE, no register update, no TRANS_CNT increment.
REQ-022 Register map, decoded on latched paddr[5:2]: 0x00 ID (RO, 0xA5B0_0001); 0x04 CTRL (RW, reset 0); 0x08 STATUS (W1C, bits 7:0); 0x0C TRANS_CNT (RO); 0x10-0x3C SCRATCH[0..11] (RW).
REQ-023 pslverr_o SHALL be 1 only when pready_o is 1 and at least one of the following holds: paddr[1:0]!=0; paddr[ADDR_WIDTH-1:6]!=0; write to ID; write to TRANS_CNT.
REQ-024 An errored write SHALL modify no register; an errored read SHALL return 0.
REQ-025 prdata_o SHALL be the addressed register value while pready_o & ~pwrite, else 0; the STATUS value returned SHALL be the one sampled at completion.
REQ-026 STATUS[i] SHALL set on irq_src_i[i]; a write of 1 to bit i SHALL clear it; when set and clear coincide, set wins.
REQ-027 irq_o SHALL equal |(STATUS[7:0] & CTRL[7:0]), registered (one-cycle latency).
REQ-028 TRANS_CNT SHALL count completed transfers, erroring transfers included, and wrap from 0xFFFF_FFFF to 0.

Reset
REQ-029 rst SHALL force IDLE, counter 0, CTRL/STATUS/TRANS_CNT/SCRATCH to 0, and irq_o/pready_o/pslverr_o/prdata_o to 0.
REQ-030 rst asserted mid-ACCESS SHALL abandon the transfer with no write committed; the slave SHALL then accept a fresh setup phase.

Structure
REQ-031 Package apb_slave_pkg SHALL hold the state enum, the register offset constants, ID_VALUE and the STATUS width.
REQ-032 The register array and the W1C/RO logic SHALL live in one sub-module, apb_slave_regbank; the FSM and wait counter stay in apb_reg_slave.

Verification
REQ-033 WAIT_CYCLES=2: write 0x1234_5678 to 0x10, then read 0x10 -> pready_o high on the 4th cycle of each transfer; read returns 0x1234_5678; pslverr_o=0; TRANS_CNT=2.
REQ-034 Write to 0x00, read 0x44, read 0x06 -> pslverr_o=1 on each; ID still 0xA5B0_0001; error reads return 0.
REQ-035 CTRL=0x01, pulse irq_src_i[0] -> irq_o=1 after 1 cycle; write 0x01 to 0x08 in the same cycle as another irq_src_i[0] pulse -> STATUS[0] stays 1.
REQ-036 Drop psel_i during a wait state of a write to 0x14 -> SCRATCH[1] unchanged, TRANS_CNT unchanged, next transfer completes normally.
REQ-037 Assert rst mid-ACCESS with WAIT_CYCLES=3 -> outputs 0 on the next cycle; all registers 0; next read of 0x00 returns 0xA5B0_0001.
